pc_sequencer: RTL and testbench



---
 rtl/pc_sequencer.sv | 85 ++++++++
 tb/tb_pc_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/RUN/HALTED control with relative branches,
// halt, stall and a saturating retired-instruction counter.
module pc_sequencer #(
    parameter int D  = 12,
    parameter int CW = 16
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          start,
    input  logic [D-1:0]  start_addr,
    input  logic          branch_en,
    input  logic [D-1:0]  target,
    input  logic          halt_in,
    input  logic          stall,
    output logic [D-1:0]  prog_ctr,
    output logic          fetch_valid,
    output logic          done,
    output logic [CW-1:0] instr_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [D-1:0]  pc_q, pc_d;
    logic [CW-1:0] cnt_q, cnt_d;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    // start outranks stall, halt and branch in every state
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        if (start) begin
            state_d = RUN;
            pc_d    = start_addr;
            cnt_d   = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (!stall) begin
                        cnt_d = sat_inc(cnt_q);
                        if (halt_in) begin
                            state_d = HALTED;
                        end else if (branch_en) begin
                            pc_d = pc_q + target;
                        end else begin
                            pc_d = pc_q + 1'b1;
                        end
                    end
                end
                IDLE, HALTED: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign prog_ctr    = pc_q;
    assign instr_count = cnt_q;
    assign fetch_valid = (state_q == RUN);
    assign done        = (state_q == HALTED);

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus queues hand-computed expected
// outputs, a monitor process compares them against the DUT when signalled.
module tb_pc_sequencer;

    localparam int D  = 12;
    localparam int CW = 4;

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b1;
    logic          start = 1'b0;
    logic [D-1:0]  start_addr = '0;
    logic          branch_en = 1'b0;
    logic [D-1:0]  target = '0;
    logic          halt_in = 1'b0;
    logic          stall = 1'b0;
    logic [D-1:0]  prog_ctr;
    logic          fetch_valid;
    logic          done;
    logic [CW-1:0] instr_count;

    pc_sequencer #(.D(D), .CW(CW)) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .start       (start),
        .start_addr  (start_addr),
        .branch_en   (branch_en),
        .target      (target),
        .halt_in     (halt_in),
        .stall       (stall),
        .prog_ctr    (prog_ctr),
        .fetch_valid (fetch_valid),
        .done        (done),
        .instr_count (instr_count)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string         nm;
        logic [D-1:0]  pc;
        logic          fv;
        logic          dn;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    event sample_ev;
    int   checks = 0;
    int   errors = 0;

    always begin
        @(sample_ev);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_sample: no expected entry queued");
        end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (prog_ctr !== e.pc || fetch_valid !== e.fv || done !== e.dn || instr_count !== e.cnt) begin
                errors++;
                $display("FAIL %s: got pc=%h fv=%b done=%b cnt=%0d, want pc=%h fv=%b done=%b cnt=%0d",
                         e.nm, prog_ctr, fetch_valid, done, instr_count, e.pc, e.fv, e.dn, e.cnt);
            end
        end
    end

    task automatic expect_st(input string nm, input logic [D-1:0] pc, input logic fv,
                             input logic dn, input logic [CW-1:0] cnt);
        exp_t e;
        e.nm = nm; e.pc = pc; e.fv = fv; e.dn = dn; e.cnt = cnt;
        exp_q.push_back(e);
        ->sample_ev;
    endtask

    task automatic drive(input logic st, input logic [D-1:0] sa, input logic br,
                         input logic [D-1:0] tg, input logic hl, input logic sl);
        start = st; start_addr = sa; branch_en = br; target = tg; halt_in = hl; stall = sl;
    endtask

    task automatic tick(input string nm, input logic [D-1:0] pc, input logic fv,
                        input logic dn, input logic [CW-1:0] cnt);
        @(posedge Clk);
        #1;
        expect_st(nm, pc, fv, dn, cnt);
    endtask

    initial begin
        // Power-on asynchronous reset
        #1 Reset_n = 1'b0;
        #1 expect_st("reset_async", 12'h000, 1'b0, 1'b0, 4'd0);
        drive(1'b1, 12'h3AB, 1'b0, 12'h000, 1'b0, 1'b0);
        tick("reset_hold", 12'h000, 1'b0, 1'b0, 4'd0);
        Reset_n = 1'b1;
        drive(1'b0, 12'h3AB, 1'b0, 12'h000, 1'b0, 1'b0);
        tick("idle_wait", 12'h000, 1'b0, 1'b0, 4'd0);

        // Plain sequential run
        drive(1'b1, 12'h010, 1'b0, 12'h000, 1'b0, 1'b0);
        tick("start_010", 12'h010, 1'b1, 1'b0, 4'd0);
        drive(1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0);
        tick("seq_011", 12'h011, 1'b1, 1'b0, 4'd1);
        tick("seq_012", 12'h012, 1'b1, 1'b0, 4'd2);
        tick("seq_013", 12'h013, 1'b1, 1'b0, 4'd3);

        // Backward and forward relative branches, restart from RUN
        drive(1'b1, 12'h0A0, 1'b0, 12'h000, 1'b0, 1'b0);
        tick("restart_0A0", 12'h0A0, 1'b1, 1'b0, 4'd0);
        drive(1'b0, 12'h000, 1'b1, 12'hF9B, 1'b0, 1'b0);
        tick("branch_neg101", 12'h03B, 1'b1, 1'b0, 4'd1);
        drive(1'b0, 12'h000, 1'b1, 12'h009, 1'b0, 1'b0);
        tick("branch_pos9", 12'h044, 1'b1, 1'b0, 4'd2);

        // Wrap-around on increment and branch
        drive(1'b1, 12'hFFF, 1'b0, 12'h000, 1'b0, 1'b0);
        tick("start_FFF", 12'hFFF, 1'b1, 1'b0, 4'd0);
        drive(1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0);
        tick("wrap_000", 12'h000, 1'b1, 1'b0, 4'd1);
        tick("seq_001", 12'h001, 1'b1, 1'b0, 4'd2);
        tick("seq_002", 12'h002, 1'b1, 1'b0, 4'd3);
        drive(1'b0, 12'h000, 1'b1, 12'hFFC, 1'b0, 1'b0);
        tick("branch_wrap_FFE", 12'hFFE, 1'b1, 1'b0, 4'd4);
        drive(1'b0, 12'h000, 1'b1, 12'h000, 1'b0, 1'b0);
        tick("self_loop", 12'hFFE, 1'b1, 1'b0, 4'd5);

        // Stall freezes everything, branch/halt ignored; start overrides stall
        drive(1'b0, 12'h000, 1'b1, 12'h007, 1'b0, 1'b1);
        tick("stall_1", 12'hFFE, 1'b1, 1'b0, 4'd5);
        tick("stall_2", 12'hFFE, 1'b1, 1'b0, 4'd5);
        drive(1'b0, 12'h000, 1'b1, 12'h007, 1'b1, 1'b1);
        tick("stall_3_halt", 12'hFFE, 1'b1, 1'b0, 4'd5);
        tick("stall_4_halt", 12'hFFE, 1'b1, 1'b0, 4'd5);
        drive(1'b1, 12'h020, 1'b1, 12'h007, 1'b1, 1'b1);
        tick("start_in_stall", 12'h020, 1'b1, 1'b0, 4'd0);

        // Halt has priority over branch; HALTED holds
        drive(1'b0, 12'h000, 1'b1, 12'h005, 1'b1, 1'b0);
        tick("halt_020", 12'h020, 1'b0, 1'b1, 4'd1);
        drive(1'b0, 12'h000, 1'b1, 12'h005, 1'b0, 1'b0);
        tick("halted_hold1", 12'h020, 1'b0, 1'b1, 4'd1);
        tick("halted_hold2", 12'h020, 1'b0, 1'b1, 4'd1);

        // Restart from HALTED, then saturate the counter
        drive(1'b1, 12'h100, 1'b0, 12'h000, 1'b0, 1'b0);
        tick("start_100", 12'h100, 1'b1, 1'b0, 4'd0);
        drive(1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0);
        for (int i = 1; i <= 17; i++) begin
            tick("sat_run", 12'h100 + 12'(i), 1'b1, 1'b0, (i > 15) ? 4'd15 : 4'(i));
        end

        // Asynchronous reset between edges mid-RUN
        @(posedge Clk);
        #3 Reset_n = 1'b0;
        #1 expect_st("reset_midrun", 12'h000, 1'b0, 1'b0, 4'd0);
        @(negedge Clk);
        #1 Reset_n = 1'b1;
        tick("post_reset_idle1", 12'h000, 1'b0, 1'b0, 4'd0);
        tick("post_reset_idle2", 12'h000, 1'b0, 1'b0, 4'd0);
        drive(1'b1, 12'h055, 1'b0, 12'h000, 1'b0, 1'b0);
        tick("start_055", 12'h055, 1'b1, 1'b0, 4'd0);
        drive(1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0);
        tick("seq_056", 12'h056, 1'b1, 1'b0, 4'd1);

        // Bounded drain of the scoreboard
        for (int t = 0; t < 20 && exp_q.size() != 0; t++) #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
